// File: rtl/posit_encode_sumval_es3_if.sv
// Bus bundle for the posit<32,3> sum-value encoder: serialized raw value in, packed posit out.
// start qualifies in1 for one cycle; done qualifies result for one cycle; there is no ready, so the
// producer may present a value every cycle and the consumer must take every done.
interface posit_encode_sumval_es3_if;
    logic        start;
    logic [41:0] in1;
    logic [31:0] result;
    logic        done;

    modport master (output start, output in1, input result, input done);
    modport slave  (input start, input in1, output result, output done);
endinterface

// File: rtl/posit_encode_sumval_es3.sv
// Four-stage encoder: R0 capture, R1 regime build, R2 round-to-nearest-even, R3 sign/specials.
// Fixed latency of four registers, one value per cycle, no backpressure.
module posit_encode_sumval_es3 (
    input  logic                        clk,
    input  logic                        rst_n,
    posit_encode_sumval_es3_if.slave    bus
);
    // R0
    logic        v0_q, v0_d;
    logic [41:0] in0_q;

    // R1
    logic        v1_q, sgn1_q, inf1_q, zero1_q;
    logic [30:0] body1_q, body1_d;
    logic        guard1_q, guard1_d;
    logic        sticky1_q, sticky1_d;

    // R2
    logic        v2_q, sgn2_q, inf2_q, zero2_q;
    logic [30:0] body2_q, body2_d;

    // R3
    logic        done_q;
    logic [31:0] result_q, result_d;

    logic              sgn0, inf0, zero0;
    logic signed [8:0] scale0;
    logic [29:0]       frac0;
    logic              sat_hi, sat_lo, pos;
    logic [5:0]        k6, rl;
    logic [63:0]       base, fill, shifted;
    logic              inc;
    logic [30:0]       rounded;

    assign sgn0   = in0_q[41];
    assign scale0 = in0_q[40:32];
    assign frac0  = in0_q[31:2];
    assign inf0   = in0_q[1];
    assign zero0  = in0_q[0];

    // An unknown start falls into the else path and is not accepted.
    always_comb begin
        v0_d = 1'b0;
        if (bus.start) v0_d = 1'b1;
    end

    // k = scale >>> 3 keeps scale[8:3] as its low six bits; rl is the regime run length.
    // The regime is formed by shifting {terminator, e, frac} right with the run value as fill.
    always_comb begin
        sat_hi    = scale0 > 9'sd240;
        sat_lo    = scale0 < -9'sd240;
        k6        = scale0[8:3];
        pos       = ~k6[5];
        rl        = pos ? (k6 + 6'd1) : (6'd0 - k6);
        fill      = {64{pos}};
        base      = {~pos, scale0[2:0], frac0, 30'd0};
        shifted   = fill ^ ((base ^ fill) >> rl);
        body1_d   = shifted[63:33];
        guard1_d  = shifted[32];
        sticky1_d = |shifted[31:0];
        if (sat_hi) begin
            body1_d   = 31'h7FFF_FFFF;
            guard1_d  = 1'b0;
            sticky1_d = 1'b0;
        end else if (sat_lo) begin
            body1_d   = 31'd1;
            guard1_d  = 1'b0;
            sticky1_d = 1'b0;
        end
    end

    // Ties to even; an all-ones body never increments so maxpos cannot wrap into NaR.
    always_comb begin
        inc     = guard1_q & (sticky1_q | body1_q[0]);
        rounded = body1_q;
        if (inc && (body1_q != 31'h7FFF_FFFF)) rounded = body1_q + 31'd1;
        body2_d = (rounded == 31'd0) ? 31'd1 : rounded;
    end

    always_comb begin
        result_d = {1'b0, body2_q};
        if (inf2_q)       result_d = 32'h8000_0000;
        else if (zero2_q) result_d = 32'h0000_0000;
        else if (sgn2_q)  result_d = 32'd0 - {1'b0, body2_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q      <= 1'b0;
            in0_q     <= '0;
            v1_q      <= 1'b0;
            sgn1_q    <= 1'b0;
            inf1_q    <= 1'b0;
            zero1_q   <= 1'b0;
            body1_q   <= '0;
            guard1_q  <= 1'b0;
            sticky1_q <= 1'b0;
            v2_q      <= 1'b0;
            sgn2_q    <= 1'b0;
            inf2_q    <= 1'b0;
            zero2_q   <= 1'b0;
            body2_q   <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            v0_q      <= v0_d;
            in0_q     <= bus.in1;
            v1_q      <= v0_q;
            sgn1_q    <= sgn0;
            inf1_q    <= inf0;
            zero1_q   <= zero0;
            body1_q   <= body1_d;
            guard1_q  <= guard1_d;
            sticky1_q <= sticky1_d;
            v2_q      <= v1_q;
            sgn2_q    <= sgn1_q;
            inf2_q    <= inf1_q;
            zero2_q   <= zero1_q;
            body2_q   <= body2_d;
            done_q    <= v2_q;
            if (v2_q) result_q <= result_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_posit_encode_sumval_es3.sv
// Bench for posit_encode_sumval_es3: directed vectors plus random values against a bit-list model.
module tb_posit_encode_sumval_es3;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_cnt     = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  string       tag_q[$];

  posit_encode_sumval_es3_if bus ();

  posit_encode_sumval_es3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // reference: build the body as an explicit bit list, then round
  function automatic logic [31:0] ref_posit(logic s, int scale, logic [29:0] f, logic inf, logic z);
    bit q[$];
    int e;
    int k;
    longint mag;
    logic [30:0] body;
    bit guard;
    bit sticky;
    if (inf) return 32'h8000_0000;
    if (z) return 32'h0000_0000;
    if (scale > 240) mag = 64'h7FFF_FFFF;
    else if (scale < -240) mag = 1;
    else begin
      e = ((scale % 8) + 8) % 8;
      k = (scale - e) / 8;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(e[i]);
      for (int i = 29; i >= 0; i--) q.push_back(f[i]);
      body = '0;
      for (int i = 0; i < 31; i++) body = {body[29:0], q[i]};
      guard  = q[31];
      sticky = 1'b0;
      for (int i = 32; i < q.size(); i++) sticky = sticky | q[i];
      mag = longint'(body);
      if (guard && (sticky || body[0])) mag++;
      if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
      if (mag == 0) mag = 1;
    end
    return s ? 32'(-mag) : 32'(mag);
  endfunction

  // driver tasks
  task automatic drive(input string tag, input logic s, input int scale, input logic [29:0] f,
                       input logic inf, input logic z, input logic [31:0] exp_val);
    logic [8:0] sc;
    sc = 9'(scale);
    @(negedge clk);
    bus.start = 1'b1;
    bus.in1   = {s, sc, f, inf, z};
    exp_q.push_back(exp_val);
    exp_cyc_q.push_back(cyc + 4);
    tag_q.push_back(tag);
  endtask

  task automatic send_model(input logic s, input int scale, input logic [29:0] f,
                            input logic inf, input logic z);
    drive("random", s, scale, f, inf, z, ref_posit(s, scale, f, inf, z));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.in1   = '0;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    tests_run++;
    assert (exp_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  // scoreboard: every done must match the oldest expected value on its exact cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done === 1'b1) begin
        done_cnt++;
        tests_run++;
        assert (exp_q.size() > 0) else begin
          tests_failed++;
          $error("FAIL unexpected_done result=%h required=no_done", bus.result);
        end
        if (exp_q.size() > 0) begin
          tests_run += 2;
          assert (bus.result === exp_q[0]) else begin
            tests_failed++;
            $error("FAIL %s result=%h required=%h", tag_q[0], bus.result, exp_q[0]);
          end
          assert (cyc === exp_cyc_q[0]) else begin
            tests_failed++;
            $error("FAIL %s_latency cycle=%0d required=%0d", tag_q[0], cyc, exp_cyc_q[0]);
          end
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
          void'(tag_q.pop_front());
        end
      end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        tests_run++;
        assert (bus.done === 1'b1) else begin
          tests_failed++;
          $error("FAIL %s_missing_done done=%b required=1", tag_q[0], bus.done);
        end
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        void'(tag_q.pop_front());
      end
    end
  end

  initial begin : stim
    int n_done;
    int mode;
    int scale;
    bus.start = 1'b0;
    bus.in1   = '0;

    // reset
    #1 rst_n = 1'b0;
    #1;
    tests_run += 2;
    assert (bus.done === 1'b0) else begin
      tests_failed++;
      $error("FAIL reset_done done=%b required=0", bus.done);
    end
    assert (bus.result === 32'h0) else begin
      tests_failed++;
      $error("FAIL reset_result result=%h required=00000000", bus.result);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1.0 and -1.0
    drive("one", 1'b0, 0, 30'h0, 1'b0, 1'b0, 32'h4000_0000);
    idle(5);
    drive("neg_one", 1'b1, 0, 30'h0, 1'b0, 1'b0, 32'hC000_0000);
    idle(5);

    // back-to-back stream
    drive("s_scale1", 1'b0, 1, 30'h0, 1'b0, 1'b0, 32'h4400_0000);
    drive("s_fracmsb", 1'b0, 0, 30'h2000_0000, 1'b0, 1'b0, 32'h4200_0000);
    drive("s_scale8", 1'b0, 8, 30'h0, 1'b0, 1'b0, 32'h6000_0000);
    drive("s_scalem1", 1'b0, -1, 30'h0, 1'b0, 1'b0, 32'h3C00_0000);
    idle(6);

    // specials and saturation
    drive("nar", 1'b0, 5, 30'h1234, 1'b1, 1'b1, 32'h8000_0000);
    drive("neg_zero", 1'b1, 17, 30'h3FFF_FFFF, 1'b0, 1'b1, 32'h0000_0000);
    drive("sat_hi", 1'b0, 250, 30'h0, 1'b0, 1'b0, 32'h7FFF_FFFF);
    drive("sat_lo", 1'b0, -250, 30'h0, 1'b0, 1'b0, 32'h0000_0001);
    drive("sat_lo_neg", 1'b1, -250, 30'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // rounding near maxpos
    drive("rnd_232", 1'b0, 232, 30'h0, 1'b0, 1'b0, 32'h7FFF_FFFE);
    drive("rnd_236_tie", 1'b0, 236, 30'h0, 1'b0, 1'b0, 32'h7FFF_FFFE);
    drive("rnd_237", 1'b0, 237, 30'h0, 1'b0, 1'b0, 32'h7FFF_FFFF);
    drive("rnd_240_ones", 1'b0, 240, 30'h3FFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF);
    idle(1);
    drain();

    // unknown start must not be accepted
    n_done = done_cnt;
    @(negedge clk);
    bus.start = 1'bx;
    bus.in1   = {1'b0, 9'd3, 30'h0, 1'b0, 1'b0};
    idle(7);
    tests_run++;
    assert (done_cnt == n_done) else begin
      tests_failed++;
      $error("FAIL x_start dones=%0d required=%0d", done_cnt - n_done, 0);
    end

    // random stream
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        mode = int'($urandom_range(0, 2));
        if (mode == 0) scale = int'($urandom_range(0, 511)) - 256;
        else if (mode == 1) scale = (($urandom_range(0, 1) == 1) ? 1 : -1) * int'($urandom_range(226, 252));
        else scale = int'($urandom_range(0, 40)) - 20;
        send_model(1'($urandom_range(0, 1)), scale, 30'($urandom),
                   ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      end else begin
        idle(1);
      end
    end
    idle(1);
    drain();

    // reset with two values in flight
    drive("flush_a", 1'b0, 9, 30'h0, 1'b0, 1'b0, 32'h6200_0000);
    drive("flush_b", 1'b0, 10, 30'h0, 1'b0, 1'b0, 32'h6400_0000);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    tag_q.delete();
    #1;
    tests_run += 2;
    assert (bus.done === 1'b0) else begin
      tests_failed++;
      $error("FAIL flush_done done=%b required=0", bus.done);
    end
    assert (bus.result === 32'h0) else begin
      tests_failed++;
      $error("FAIL flush_result result=%h required=00000000", bus.result);
    end
    n_done = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    tests_run += 2;
    assert (done_cnt == n_done) else begin
      tests_failed++;
      $error("FAIL flush_no_done dones=%0d required=%0d", done_cnt - n_done, 0);
    end
    assert (bus.result === 32'h0) else begin
      tests_failed++;
      $error("FAIL flush_hold result=%h required=00000000", bus.result);
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
